demux12_32bits: RTL

Registered 1-to-2 demultiplexer for 32-bit words: the splitting counterpart of the datapath 2:1 mux. Each input word is steered to output A or output B by a per-word select and buffered in a 2-entry FIFO on that output. The ports use valid/ready handshakes, so the two destinations drain independently. Per-output delivered-word counters support debug and bench checks.

---
 rtl/demux12_32bits.sv | 78 +++++++
 1 files changed

// File: rtl/demux12_32bits.sv
// demux12_32bits: steers 32-bit words to one of two 2-entry valid/ready FIFOs with delivered-word counters.
module demux12_32bits_fifo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       level_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q, rd_q, pop;
  logic [1:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q;
  assign pop = valid_o & ready_i & !rst;
  always_ff @(posedge clk)
    level_q <= rst ? 2'd0 : level_d;
  always_comb
    level_d = (push_i & !pop) ? level_q + 2'd1 : (pop & !push_i) ? level_q - 2'd1 : level_q;
  always_comb begin
    valid_o = level_q != 2'd0;
    data_o  = mem_q[rd_q];
    level_o = level_q;
    cnt_o   = cnt_q;
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk)
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q ^ push_i;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_q + CNT_W'(pop);
    end
endmodule

module demux12_32bits #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A_data,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B_data,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [1:0]       A_level,
  output logic [1:0]       B_level,
  output logic [CNT_W-1:0] A_cnt,
  output logic [CNT_W-1:0] B_cnt
);
  logic acc;
  // in_ready depends only on the selected FIFO's level, never on the consumer readies
  assign in_ready = !rst & (in_ctrl ? (B_level != 2'd2) : (A_level != 2'd2));
  assign acc      = in_valid & in_ready;
  demux12_32bits_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst(rst), .push_i(acc & !in_ctrl), .data_i(in_data), .ready_i(A_ready),
    .data_o(A_data), .valid_o(A_valid), .level_o(A_level), .cnt_o(A_cnt)
  );
  demux12_32bits_fifo #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst(rst), .push_i(acc & in_ctrl), .data_i(in_data), .ready_i(B_ready),
    .data_o(B_data), .valid_o(B_valid), .level_o(B_level), .cnt_o(B_cnt)
  );
endmodule
